bias_fetch_ctrl: RTL and testbench

Sequencer for the single-port bias RAM of the NPU core. Each layer runs a LOAD phase that writes the per-output-layer bias words from the loader stream into RAM at ascending addresses. A CALC phase follows: it walks the output layers in step with NPE result beats and presents the current layer's bias to the accumulate/output stage. It replaces ad-hoc address counting with one FSM that owns every RAM port signal.

---
 rtl/bias_fetch_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_bias_fetch_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bias_fetch_ctrl
// Purpose  : Bias RAM sequencer. LOAD writes per-layer bias words from the
//            loader stream. CALC walks the layers in step with NPE beats.
//            Optional protocol checking is compiled in by BIAS_FETCH_ERR_CHK_EN.
// Revision : 1.0  initial release
// ============================================================================
module bias_fetch_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cfg_start,
    input  logic [7:0]            i_output_layers,
    input  logic [7:0]            i_out_x_length,
    input  logic                  i_wr_vld,
    input  logic [DATA_WIDTH-1:0] i_wr_dat,
    output logic                  o_wr_rdy,
    input  logic                  i_calc_en,
    input  logic                  i_npe_dat_vld,
    output logic                  o_ram_en,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_wdat,
    input  logic [DATA_WIDTH-1:0] i_ram_rdat,
    output logic [DATA_WIDTH-1:0] o_bias_dat,
    output logic                  o_bias_vld,
    output logic                  o_load_done,
    output logic                  o_calc_done,
    output logic                  o_busy,
    output logic                  o_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2,
        S_CALC  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [8:0]            r_layers;
    logic [8:0]            r_xlen;
    logic [8:0]            r_wr_cnt;
    logic [8:0]            r_x_cnt;
    logic [8:0]            r_layer_cnt;
    logic                  r_rd_en;
    logic                  r_rd_pend;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [DATA_WIDTH-1:0] r_bias_dat;
    logic                  r_bias_vld;
    logic                  r_load_done;
    logic                  r_calc_done;

    logic w_cfg_take;
    logic w_calc_go;
    logic w_wr_xfer;
    logic w_wr_last;
    logic w_beat;
    logic w_x_last;
    logic w_layer_last;
    logic w_calc_last;

    assign w_cfg_take   = i_cfg_start && ((r_state == S_IDLE) || (r_state == S_READY));
    assign w_calc_go    = (r_state == S_READY) && i_calc_en && !i_cfg_start;
    assign w_wr_xfer    = (r_state == S_LOAD) && i_wr_vld;
    assign w_wr_last    = w_wr_xfer && (r_wr_cnt == r_layers - 9'd1);
    assign w_beat       = (r_state == S_CALC) && i_npe_dat_vld;
    assign w_x_last     = w_beat && (r_x_cnt == r_xlen - 9'd1);
    assign w_layer_last = (r_layer_cnt == r_layers - 9'd1);
    assign w_calc_last  = w_x_last && w_layer_last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_cfg_take)  w_state_nxt = S_LOAD;
            S_LOAD:  if (w_wr_last)   w_state_nxt = S_READY;
            S_READY: begin
                if (w_cfg_take)      w_state_nxt = S_LOAD;
                else if (w_calc_go)  w_state_nxt = S_CALC;
            end
            S_CALC:  if (w_calc_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_layers    <= 9'd0;
            r_xlen      <= 9'd0;
            r_wr_cnt    <= 9'd0;
            r_x_cnt     <= 9'd0;
            r_layer_cnt <= 9'd0;
            r_rd_en     <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_rd_addr   <= '0;
            r_bias_dat  <= '0;
            r_bias_vld  <= 1'b0;
            r_load_done <= 1'b0;
            r_calc_done <= 1'b0;
        end else begin
            r_load_done <= w_wr_last;
            r_calc_done <= w_calc_last;
            r_rd_pend   <= r_rd_en;
            r_rd_en     <= 1'b0;

            // 8-bit fields extend to 9 bits so that 0 encodes 256
            if (w_cfg_take) begin
                r_layers <= {(i_output_layers == 8'd0), i_output_layers};
                r_xlen   <= {(i_out_x_length == 8'd0), i_out_x_length};
                r_wr_cnt <= 9'd0;
            end
            if (w_wr_xfer) begin
                r_wr_cnt <= r_wr_cnt + 9'd1;
            end

            if (w_calc_go) begin
                r_x_cnt     <= 9'd0;
                r_layer_cnt <= 9'd0;
                r_rd_en     <= 1'b1;
                r_rd_addr   <= '0;
                r_bias_vld  <= 1'b0;
            end

            if (r_rd_pend) begin
                r_bias_dat <= i_ram_rdat;
                r_bias_vld <= 1'b1;
            end

            // A layer switch wins over landing data: that data belongs to the old layer
            if (w_beat) begin
                if (w_x_last) begin
                    r_x_cnt     <= 9'd0;
                    r_layer_cnt <= r_layer_cnt + 9'd1;
                    r_bias_vld  <= 1'b0;
                    if (!w_layer_last) begin
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= ADDR_WIDTH'(r_layer_cnt + 9'd1);
                    end
                end else begin
                    r_x_cnt <= r_x_cnt + 9'd1;
                end
            end
        end
    end

    assign o_wr_rdy    = (r_state == S_LOAD);
    assign o_ram_en    = w_wr_xfer || r_rd_en;
    assign o_ram_we    = w_wr_xfer;
    assign o_ram_addr  = w_wr_xfer ? ADDR_WIDTH'(r_wr_cnt) : (r_rd_en ? r_rd_addr : '0);
    assign o_ram_wdat  = w_wr_xfer ? i_wr_dat : '0;
    assign o_bias_dat  = r_bias_dat;
    assign o_bias_vld  = r_bias_vld;
    assign o_load_done = r_load_done;
    assign o_calc_done = r_calc_done;
    assign o_busy      = (r_state != S_IDLE);

`ifdef BIAS_FETCH_ERR_CHK_EN
    logic r_err;
    logic w_err_evt;

    assign w_err_evt = (i_wr_vld && (r_state != S_LOAD))
                    || (i_npe_dat_vld && (r_state != S_CALC))
                    || (w_beat && !r_bias_vld)
                    || (i_calc_en && (r_state != S_READY));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bias_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bias_fetch_ctrl
// Purpose  : Table-driven load/calc runs against a bias RAM model, with a
//            scoreboard of expected RAM accesses and timing corner sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_bias_fetch_ctrl;
    localparam int AW = 8;
    localparam int DW = 32;
`ifdef BIAS_FETCH_ERR_CHK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_cfg_start = 1'b0;
    logic [7:0]    i_output_layers = 8'd0;
    logic [7:0]    i_out_x_length = 8'd0;
    logic          i_wr_vld = 1'b0;
    logic [DW-1:0] i_wr_dat = '0;
    logic          o_wr_rdy;
    logic          i_calc_en = 1'b0;
    logic          i_npe_dat_vld = 1'b0;
    logic          o_ram_en;
    logic          o_ram_we;
    logic [AW-1:0] o_ram_addr;
    logic [DW-1:0] o_ram_wdat;
    logic [DW-1:0] i_ram_rdat = '0;
    logic [DW-1:0] o_bias_dat;
    logic          o_bias_vld;
    logic          o_load_done;
    logic          o_calc_done;
    logic          o_busy;
    logic          o_err;

    always #5 clk = ~clk;

    bias_fetch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_cfg_start(i_cfg_start),
        .i_output_layers(i_output_layers), .i_out_x_length(i_out_x_length),
        .i_wr_vld(i_wr_vld), .i_wr_dat(i_wr_dat), .o_wr_rdy(o_wr_rdy),
        .i_calc_en(i_calc_en), .i_npe_dat_vld(i_npe_dat_vld),
        .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
        .o_ram_wdat(o_ram_wdat), .i_ram_rdat(i_ram_rdat),
        .o_bias_dat(o_bias_dat), .o_bias_vld(o_bias_vld),
        .o_load_done(o_load_done), .o_calc_done(o_calc_done),
        .o_busy(o_busy), .o_err(o_err)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
    } acc_t;

    typedef struct {
        logic [7:0]    lay;
        logic [7:0]    xl;
        bit            stall;
        logic [DW-1:0] base;
        int            exp_l;
        int            exp_x;
    } vec_t;

    acc_t          q_exp[$];
    acc_t          m_e;
    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] exp_word [0:255];
    logic          p_en = 1'b0;
    logic          p_we = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_dat = '0;
    vec_t          vecs [5];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor and RAM model; accesses are captured mid-cycle
    always @(negedge clk) begin
        p_en   = o_ram_en;
        p_we   = o_ram_we;
        p_addr = o_ram_addr;
        p_dat  = o_ram_wdat;
        if (o_ram_en && !i_rst) begin
            if (q_exp.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL ram_access: unexpected we=%0b addr=0x%0h got access, expected none", o_ram_we, o_ram_addr);
            end else begin
                m_e = q_exp.pop_front();
                chk("ram_we", o_ram_we, m_e.we);
                chk("ram_addr", o_ram_addr, m_e.addr);
                if (m_e.we) chk("ram_wdat", o_ram_wdat, m_e.dat);
            end
        end
    end

    always @(posedge clk) begin
        if (p_en) begin
            if (p_we) mem[p_addr] <= p_dat;
            else      i_ram_rdat  <= mem[p_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        i_cfg_start   = 1'b0;
        i_calc_en     = 1'b0;
        i_wr_vld      = 1'b0;
        i_npe_dat_vld = 1'b0;
        i_wr_dat      = '0;
    endtask

    task automatic chk_reset_vals();
        @(negedge clk);
        chk("rst_wr_rdy", o_wr_rdy, 0);
        chk("rst_ram_en", o_ram_en, 0);
        chk("rst_ram_we", o_ram_we, 0);
        chk("rst_ram_addr", o_ram_addr, 0);
        chk("rst_ram_wdat", o_ram_wdat, 0);
        chk("rst_bias_dat", o_bias_dat, 0);
        chk("rst_bias_vld", o_bias_vld, 0);
        chk("rst_load_done", o_load_done, 0);
        chk("rst_calc_done", o_calc_done, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_err", o_err, 0);
    endtask

    task automatic do_load(input logic [7:0] lay, input logic [7:0] xl, input bit stall,
                           input logic [DW-1:0] base, input int nl);
        step();
        i_cfg_start     = 1'b1;
        i_output_layers = lay;
        i_out_x_length  = xl;
        for (int i = 0; i < nl; i++) begin
            step();
            chk("wr_rdy", o_wr_rdy, 1);
            chk("load_done_early", o_load_done, 0);
            if (stall) begin
                @(negedge clk);
                chk("stall_no_write", o_ram_en, 0);
                step();
            end
            i_wr_vld    = 1'b1;
            i_wr_dat    = base + DW'(i);
            exp_word[i] = base + DW'(i);
            q_exp.push_back('{1'b1, AW'(i), base + DW'(i)});
        end
        step();
        chk("load_done", o_load_done, 1);
        chk("ready_busy", o_busy, 1);
        chk("ready_no_rdy", o_wr_rdy, 0);
        step();
        chk("load_done_pulse", o_load_done, 0);
    endtask

    task automatic do_calc(input int nl, input int nx, input int abort_layer);
        int waits;
        step();
        i_calc_en = 1'b1;
        q_exp.push_back('{1'b0, '0, '0});
        for (int l = 0; l < nl; l++) begin
            for (int x = 0; x < nx; x++) begin
                waits = 0;
                step();
                while (!o_bias_vld && waits < 8) begin
                    waits++;
                    step();
                end
                if (x == 0) chk("vld_gap", waits, 2);
                else        chk("vld_hold", waits, 0);
                if (l == abort_layer) begin
                    i_rst = 1'b1;
                    return;
                end
                chk("bias_dat", o_bias_dat, exp_word[l]);
                chk("busy_calc", o_busy, 1);
                i_npe_dat_vld = 1'b1;
                if (x == nx - 1 && l < nl - 1) q_exp.push_back('{1'b0, AW'(l + 1), '0});
            end
        end
        step();
        chk("calc_done", o_calc_done, 1);
        chk("calc_end_busy", o_busy, 0);
        chk("calc_end_vld", o_bias_vld, 0);
        step();
        chk("calc_done_pulse", o_calc_done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'd4, 8'd3, 1'b0, 32'h0000_00A0, 4, 3};
        vecs[1] = '{8'd0, 8'd1, 1'b0, 32'h0000_1000, 256, 1};
        vecs[2] = '{8'd5, 8'd2, 1'b1, 32'h0000_00B0, 5, 2};
        vecs[3] = '{8'd1, 8'd0, 1'b0, 32'h0000_00C0, 1, 256};
        vecs[4] = '{8'd3, 8'd1, 1'b1, 32'h55AA_0000, 3, 1};

        repeat (3) @(posedge clk);
        #1;
        i_rst = 1'b0;
        chk_reset_vals();

        for (int v = 0; v < 5; v++) begin
            do_load(vecs[v].lay, vecs[v].xl, vecs[v].stall, vecs[v].base, vecs[v].exp_l);
            do_calc(vecs[v].exp_l, vecs[v].exp_x, -1);
            chk("err_clean", o_err, 0);
        end

        // Reset while CALC sits at layer 2, then a normal run
        do_load(8'd4, 8'd2, 1'b0, 32'h0000_00D0, 4);
        do_calc(4, 2, 2);
        step();
        i_rst = 1'b0;
        chk_reset_vals();
        do_load(8'd2, 8'd2, 1'b1, 32'h0000_00E0, 2);
        do_calc(2, 2, -1);

        // Beat during a layer-switch gap
        do_load(8'd3, 8'd1, 1'b0, 32'h0000_00F0, 3);
        step();
        i_calc_en = 1'b1;
        q_exp.push_back('{1'b0, 8'd0, '0});
        step();
        step();
        step();
        chk("gap_vld", o_bias_vld, 1);
        chk("gap_dat", o_bias_dat, 32'h0000_00F0);
        i_npe_dat_vld = 1'b1;
        q_exp.push_back('{1'b0, 8'd1, '0});
        step();
        chk("gap_vld_low", o_bias_vld, 0);
        chk("err_before", o_err, 0);
        i_npe_dat_vld = 1'b1;
        q_exp.push_back('{1'b0, 8'd2, '0});
        step();
        chk("err_set", o_err, ERR_EN);
        step();
        chk("err_sticky", o_err, ERR_EN);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("err_cleared", o_err, 0);
        chk("err_rst_busy", o_busy, 0);

        step();
        chk("sb_empty", q_exp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
